// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the 4x4 systolic array sequencer.
package systolic_ctrl_pkg;

   localparam int ARR_N  = 4;
   localparam int LANE_W = 8;
   localparam int WORD_W = ARR_N * LANE_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_HOLD
   } state_t;

   // Bit offset of lane `lane` (0-based) inside a packed 32-bit buffer word.
   function automatic int lane_lo(input int lane);
      return lane * LANE_W;
   endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Tile request, buffer read and array edge signals of the systolic sequencer.
interface systolic_ctrl_if
   import systolic_ctrl_pkg::*;
#(
   parameter int AW = 10,
   parameter int KW = 10
) ();

   logic              start;
   logic [KW-1:0]     k_len;
   logic [AW-1:0]     a_base;
   logic [AW-1:0]     b_base;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic              a_rd_en;
   logic [AW-1:0]     a_rd_addr;
   logic [WORD_W-1:0] a_rd_data;
   logic              b_rd_en;
   logic [AW-1:0]     b_rd_addr;
   logic [WORD_W-1:0] b_rd_data;
   logic              arr_clear;
   logic [WORD_W-1:0] arr_ifmap;
   logic [WORD_W-1:0] arr_weight;

   modport master (
      input  start, k_len, a_base, b_base, out_ready, a_rd_data, b_rd_data,
      output busy, out_valid, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
             arr_clear, arr_ifmap, arr_weight
   );

   modport slave (
      output start, k_len, a_base, b_base, out_ready, a_rd_data, b_rd_data,
      input  busy, out_valid, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
             arr_clear, arr_ifmap, arr_weight
   );

endinterface

// File: rtl/systolic_ctrl_skew_feeder.sv
// Triangular delay line: lane j (1-based) is delayed j-1 cycles; lanes with
// no valid word are driven to zero.
module systolic_ctrl_skew_feeder
   import systolic_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [WORD_W-1:0] data_i,
   output logic [WORD_W-1:0] data_o
);

   for (genvar gi = 0; gi < ARR_N; gi++) begin : g_lane
      localparam int LO = lane_lo(gi);

      if (gi == 0) begin : g_direct
         assign data_o[LO +: LANE_W] = valid_i ? data_i[LO +: LANE_W] : '0;
      end else begin : g_delay
         logic [gi*LANE_W-1:0]     dat_q;
         logic [gi-1:0]            vld_q;
         logic [(gi+1)*LANE_W-1:0] dat_sh;
         logic [gi:0]              vld_sh;

         // Newest byte enters at the bottom; the oldest stage drives the lane.
         assign dat_sh = {dat_q, data_i[LO +: LANE_W]};
         assign vld_sh = {vld_q, valid_i};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dat_q <= '0;
               vld_q <= '0;
            end else if (flush_i) begin
               dat_q <= '0;
               vld_q <= '0;
            end else begin
               dat_q <= dat_sh[gi*LANE_W-1:0];
               vld_q <= vld_sh[gi-1:0];
            end
         end

         assign data_o[LO +: LANE_W] = vld_sh[gi] ? dat_sh[(gi+1)*LANE_W-1 -: LANE_W] : '0;
      end
   end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the 4x4 output-stationary systolic array: clear, skewed
// feed from the tile buffers, drain, then a valid/ready result hold.
module systolic_ctrl
   import systolic_ctrl_pkg::*;
#(
   parameter int AW     = 10,
   parameter int KW     = 10,
   parameter int RD_LAT = 1,
   parameter int DRAIN  = 7
) (
   input logic             clk,
   input logic             rst_n,
   systolic_ctrl_if.master bus
);

   localparam int CW = KW + 2;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] k_q, k_d;
   logic [AW-1:0] a_base_q, a_base_d;
   logic [AW-1:0] b_base_q, b_base_d;
   logic          rd_vld_q;

   logic          rd_en;
   logic          clear;
   logic [CW-1:0] feed_last;

   // Last FEED cycle: lane 4 carries index K-1 at cnt = K + RD_LAT + 2.
   assign feed_last = {2'b00, k_q} + CW'(RD_LAT + 2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         k_q      <= '0;
         a_base_q <= '0;
         b_base_q <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         k_q      <= k_d;
         a_base_q <= a_base_d;
         b_base_q <= b_base_d;
         rd_vld_q <= rd_en;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      a_base_d = a_base_q;
      b_base_d = b_base_q;
      rd_en    = 1'b0;
      clear    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               k_d      = bus.k_len;
               a_base_d = bus.a_base;
               b_base_d = bus.b_base;
               state_d  = S_CLEAR;
            end
         end
         S_CLEAR: begin
            clear   = 1'b1;
            cnt_d   = '0;
            state_d = (k_q == '0) ? S_HOLD : S_FEED;
         end
         S_FEED: begin
            rd_en = (cnt_q < {2'b00, k_q});
            if (cnt_q == feed_last) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == CW'(DRAIN - 1)) begin
               cnt_d   = '0;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_valid = (state_q == S_HOLD);
   assign bus.arr_clear = clear;
   assign bus.a_rd_en   = rd_en;
   assign bus.b_rd_en   = rd_en;
   assign bus.a_rd_addr = rd_en ? a_base_q + AW'(cnt_q) : '0;
   assign bus.b_rd_addr = rd_en ? b_base_q + AW'(cnt_q) : '0;

   // Words return one cycle after the strobe, so the registered strobe marks them valid.
   systolic_ctrl_skew_feeder u_ifmap_skew (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (clear),
      .valid_i (rd_vld_q),
      .data_i  (bus.a_rd_data),
      .data_o  (bus.arr_ifmap)
   );

   systolic_ctrl_skew_feeder u_weight_skew (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (clear),
      .valid_i (rd_vld_q),
      .data_i  (bus.b_rd_data),
      .data_o  (bus.arr_weight)
   );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: buffer models, a behavioural 4x4 array fed by the
// sequencer's edge lanes, and a scoreboard of expected tile results.
module tb_systolic_ctrl;
   import systolic_ctrl_pkg::*;

   localparam int AW = 10;
   localparam int KW = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   systolic_ctrl_if #(.AW(AW), .KW(KW)) bus ();

   systolic_ctrl #(.AW(AW), .KW(KW), .RD_LAT(1), .DRAIN(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   bit [31:0] amem [1024];
   bit [31:0] bmem [1024];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_q [$];
   int acc [4][4];
   int hp  [4][4];
   int vp  [4][4];
   int t0_g;
   int first_i [4];
   int first_w [4];
   int nz_i    [4];
   int clr_cnt;
   int a_log [$];
   int b_log [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port buffers with one cycle read latency; idle cycles return junk.
   always @(posedge clk) begin
      bus.a_rd_data <= bus.a_rd_en ? amem[bus.a_rd_addr] : $urandom;
      bus.b_rd_data <= bus.b_rd_en ? bmem[bus.b_rd_addr] : $urandom;
   end

   function automatic int a_in(input int r, input int c);
      if (c == 0) return int'(bus.arr_ifmap[r*LANE_W +: LANE_W]);
      return hp[r][c-1];
   endfunction

   function automatic int w_in(input int r, input int c);
      if (r == 0) return int'(bus.arr_weight[c*LANE_W +: LANE_W]);
      return vp[r-1][c];
   endfunction

   // Output-stationary array: ifmaps move right, weights move down.
   always @(posedge clk) begin
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            hp[r][c]  <= a_in(r, c);
            vp[r][c]  <= w_in(r, c);
            acc[r][c] <= bus.arr_clear ? 0 : acc[r][c] + a_in(r, c) * w_in(r, c);
         end
      end
   end

   always @(negedge clk) begin : mon
      int e;
      if (bus.arr_clear) clr_cnt++;
      if (bus.a_rd_en) a_log.push_back(int'(bus.a_rd_addr));
      if (bus.b_rd_en) b_log.push_back(int'(bus.b_rd_addr));
      for (int j = 0; j < 4; j++) begin
         if (bus.arr_ifmap[j*LANE_W +: LANE_W] != 0) begin
            nz_i[j]++;
            if (first_i[j] < 0) first_i[j] = cyc - t0_g;
         end
         if (bus.arr_weight[j*LANE_W +: LANE_W] != 0 && first_w[j] < 0) first_w[j] = cyc - t0_g;
      end
      if (rst_n && bus.out_valid && bus.out_ready) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL ofmap_unexpected r=%0d c=%0d got=%0d required=no_result", r+1, c+1, acc[r][c]);
               end else begin
                  e = exp_q.pop_front();
                  if (acc[r][c] !== e) begin
                     bad++;
                     $display("FAIL ofmap r=%0d c=%0d got=%0d required=%0d", r+1, c+1, acc[r][c], e);
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_expect(input int k, input int ab, input int bb);
      bit [31:0] aw;
      bit [31:0] bw;
      int s;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) begin
               aw = amem[(ab + kk) % 1024];
               bw = bmem[(bb + kk) % 1024];
               s += int'(aw[r*8 +: 8]) * int'(bw[c*8 +: 8]);
            end
            exp_q.push_back(s);
         end
      end
   endtask

   task automatic run_tile(input int k, input int ab, input int bb, input bit auto_ready, output int lat);
      bit got;
      got = 1'b0;
      push_expect(k, ab, bb);
      a_log.delete();
      b_log.delete();
      clr_cnt = 0;
      for (int j = 0; j < 4; j++) begin
         first_i[j] = -1;
         first_w[j] = -1;
         nz_i[j]    = 0;
      end
      tick();
      bus.out_ready = auto_ready;
      bus.start     = 1'b1;
      bus.k_len     = KW'(k);
      bus.a_base    = AW'(ab);
      bus.b_base    = AW'(bb);
      t0_g          = cyc;
      tick();
      bus.start  = 1'b0;
      bus.k_len  = KW'($urandom);
      bus.a_base = AW'($urandom);
      bus.b_base = AW'($urandom);
      lat = -1;
      for (int i = 0; i < k + 40 && !got; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1;
            lat = cyc - t0_g;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL tile_timeout k=%0d got=no_out_valid required=out_valid", k);
      end
      if (got && auto_ready) begin
         tick();
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
      bus.k_len     = '0;
      bus.a_base    = '0;
      bus.b_base    = '0;
      repeat (3) @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.arr_clear !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=busy%b valid%b clr%b required=000", bus.busy, bus.out_valid, bus.arr_clear);
      end
      total++;
      if (bus.a_rd_en !== 1'b0 || bus.b_rd_en !== 1'b0 || bus.a_rd_addr !== '0 || bus.b_rd_addr !== '0) begin
         bad++;
         $display("FAIL reset_rd got=%b%b %h %h required=00 000 000", bus.a_rd_en, bus.b_rd_en, bus.a_rd_addr, bus.b_rd_addr);
      end
      total++;
      if (bus.arr_ifmap !== '0 || bus.arr_weight !== '0) begin
         bad++;
         $display("FAIL reset_lanes got=%h %h required=0 0", bus.arr_ifmap, bus.arr_weight);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_k1();
      int lat;
      amem[10'h010] = 32'h04030201;
      bmem[10'h020] = 32'h01010101;
      run_tile(1, 10'h010, 10'h020, 1'b1, lat);
      total++;
      if (lat != 14) begin bad++; $display("FAIL k1_latency got=%0d required=14", lat); end
      total++;
      if (a_log.size() != 1 || a_log[0] != 10'h010) begin
         bad++; $display("FAIL k1_a_reads got=%0d reads first=%h required=1 read at 010", a_log.size(), a_log[0]);
      end
      total++;
      if (b_log.size() != 1 || b_log[0] != 10'h020) begin
         bad++; $display("FAIL k1_b_reads got=%0d reads first=%h required=1 read at 020", b_log.size(), b_log[0]);
      end
      total++;
      if (clr_cnt != 1) begin bad++; $display("FAIL k1_clear got=%0d required=1", clr_cnt); end
      total++;
      if (first_i[0] != 3 || first_i[3] != 6) begin
         bad++; $display("FAIL k1_skew got=lane1@%0d lane4@%0d required=lane1@3 lane4@6", first_i[0], first_i[3]);
      end
      for (int j = 0; j < 4; j++) begin
         total++;
         if (nz_i[j] != 1) begin bad++; $display("FAIL k1_zero_fill lane=%0d got=%0d required=1", j+1, nz_i[j]); end
      end
   endtask

   task automatic test_k4();
      int lat;
      for (int k = 0; k < 4; k++) begin
         amem[10'h030 + k] = 32'h1 << (8 * k);
         bmem[10'h050 + k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
      end
      run_tile(4, 10'h030, 10'h050, 1'b1, lat);
      total++;
      if (lat != 17) begin bad++; $display("FAIL k4_latency got=%0d required=17", lat); end
      total++;
      if (first_w[0] != 3 || first_w[3] != 6) begin
         bad++; $display("FAIL k4_weight_skew got=lane1@%0d lane4@%0d required=lane1@3 lane4@6", first_w[0], first_w[3]);
      end
      total++;
      if (a_log.size() != 4 || a_log[0] != 10'h030 || a_log[3] != 10'h033) begin
         bad++; $display("FAIL k4_a_reads got=%0d reads required=4 reads 030..033", a_log.size());
      end
   endtask

   task automatic test_k0();
      int lat;
      run_tile(0, 10'h005, 10'h006, 1'b1, lat);
      total++;
      if (lat != 2) begin bad++; $display("FAIL k0_latency got=%0d required=2", lat); end
      total++;
      if (a_log.size() != 0 || b_log.size() != 0) begin
         bad++; $display("FAIL k0_reads got=%0d/%0d required=0/0", a_log.size(), b_log.size());
      end
      total++;
      if (clr_cnt != 1) begin bad++; $display("FAIL k0_clear got=%0d required=1", clr_cnt); end
   endtask

   task automatic test_backpressure();
      int lat;
      int na;
      int nb;
      int nc;
      run_tile(2, 10'h040, 10'h080, 1'b0, lat);
      total++;
      if (lat != 15) begin bad++; $display("FAIL bp_latency got=%0d required=15", lat); end
      na = a_log.size();
      nb = b_log.size();
      nc = clr_cnt;
      for (int i = 0; i < 20; i++) begin
         tick();
         bus.start = i[0];
         bus.k_len = KW'(5);
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL bp_hold cycle=%0d got=valid%b busy%b required=11", i, bus.out_valid, bus.busy);
         end
      end
      total++;
      if (a_log.size() != na || b_log.size() != nb || clr_cnt != nc) begin
         bad++; $display("FAIL bp_quiet got=%0d/%0d/%0d required=%0d/%0d/%0d", a_log.size(), b_log.size(), clr_cnt, na, nb, nc);
      end
      tick();
      bus.start     = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL bp_release got=valid%b busy%b required=00", bus.out_valid, bus.busy);
      end
      #1;
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || clr_cnt != nc) begin
         bad++; $display("FAIL bp_start_ignored got=busy%b clears=%0d required=busy0 clears=%0d", bus.busy, clr_cnt, nc);
      end
   endtask

   task automatic test_wrap();
      int lat;
      run_tile(3, 10'h3FE, 10'h3FF, 1'b1, lat);
      total++;
      if (lat != 16) begin bad++; $display("FAIL wrap_latency got=%0d required=16", lat); end
      total++;
      if (a_log.size() != 3 || a_log[0] != 10'h3FE || a_log[1] != 10'h3FF || a_log[2] != 10'h000) begin
         bad++; $display("FAIL wrap_a_addr got=%0d reads %h %h %h required=3FE 3FF 000", a_log.size(), a_log[0], a_log[1], a_log[2]);
      end
      total++;
      if (b_log.size() != 3 || b_log[0] != 10'h3FF || b_log[1] != 10'h000 || b_log[2] != 10'h001) begin
         bad++; $display("FAIL wrap_b_addr got=%0d reads %h %h %h required=3FF 000 001", b_log.size(), b_log[0], b_log[1], b_log[2]);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit [31:0] lane_exp;
      for (int k = 0; k < 5; k++) begin
         amem[10'h100 + k] = 32'h11223344 + k;
         bmem[10'h200 + k] = 32'h55667788 + k;
      end
      lane_exp = {16'h0, amem[10'h100][15:8], amem[10'h101][7:0]};
      tick();
      bus.out_ready = 1'b0;
      bus.start     = 1'b1;
      bus.k_len     = KW'(5);
      bus.a_base    = AW'(10'h100);
      bus.b_base    = AW'(10'h200);
      t0_g          = cyc;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      total++;
      if (bus.a_rd_en !== 1'b1 || bus.a_rd_addr !== 10'h102 || bus.arr_ifmap !== lane_exp) begin
         bad++; $display("FAIL mid_feed got=%b %h %h required=1 102 %h", bus.a_rd_en, bus.a_rd_addr, bus.arr_ifmap, lane_exp);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.a_rd_en !== 1'b0 || bus.b_rd_en !== 1'b0 || bus.a_rd_addr !== '0 ||
          bus.b_rd_addr !== '0 || bus.arr_ifmap !== '0 || bus.arr_weight !== '0 || bus.arr_clear !== 1'b0) begin
         bad++; $display("FAIL mid_async_reset got=busy%b rd%b%b %h %h %h %h required=all zero",
                         bus.busy, bus.a_rd_en, bus.b_rd_en, bus.a_rd_addr, bus.b_rd_addr, bus.arr_ifmap, bus.arr_weight);
      end
      @(negedge clk);
      rst_n = 1'b1;
      amem[10'h150] = 32'h0A0B0C0D;
      bmem[10'h160] = 32'h02030405;
      run_tile(1, 10'h150, 10'h160, 1'b1, lat);
      total++;
      if (lat != 14) begin bad++; $display("FAIL mid_restart_latency got=%0d required=14", lat); end
   endtask

   task automatic test_back_to_back();
      int lat;
      int k;
      int ab;
      int bb;
      for (int t = 0; t < 4; t++) begin
         k  = $urandom_range(1, 8);
         ab = $urandom_range(0, 1023);
         bb = $urandom_range(0, 1023);
         run_tile(k, ab, bb, 1'b1, lat);
         total++;
         if (lat != k + 13) begin bad++; $display("FAIL b2b_latency tile=%0d got=%0d required=%0d", t, lat, k + 13); end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         amem[i] = $urandom;
         bmem[i] = $urandom;
      end
      test_reset();
      test_k1();
      test_k4();
      test_k0();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_left got=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
